// File: rtl/control_loop_pi.sv
// PI feedback controller: samples an SPI ADC, runs a fixed-point PI step and
// writes the clamped correction to an SPI DAC; host access via cmd handshake.
module control_loop_pi #(
  parameter int ADC_WID      = 18,
  parameter int ADC_WID_SIZ  = 5,
  parameter int ADC_POLARITY = 1,
  parameter int ADC_PHASE    = 0,
  parameter int DAC_DATA_WID = 20,
  parameter int DAC_WID      = 24,
  parameter int DAC_WID_SIZ  = 5,
  parameter int DAC_POLARITY = 0,
  parameter int DAC_PHASE    = 1,
  parameter int CONSTS_WHOLE = 21,
  parameter int CONSTS_FRAC  = 43,
  parameter int CONSTS_SIZ   = 7,
  parameter int DELAY_WID    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_L,
  output logic                                 in_loop,
  output logic                                 adc_conv_L,
  output logic                                 adc_sck,
  input  logic                                 adc_miso,
  output logic                                 dac_ss_L,
  output logic                                 dac_sck,
  output logic                                 dac_mosi,
  input  logic                                 dac_miso,
  input  logic [CONSTS_WHOLE+CONSTS_FRAC-1:0]  word_in,
  output logic [CONSTS_WHOLE+CONSTS_FRAC-1:0]  word_out,
  input  logic                                 start_cmd,
  output logic                                 finish_cmd,
  input  logic [7:0]                           cmd
);

  localparam int CW    = CONSTS_WHOLE + CONSTS_FRAC;
  localparam int PP_W  = CW + ADC_WID + 1;
  localparam int PI_W  = CW + 32;
  localparam int ACC_W = PI_W + 1;
  localparam int TOP_W = ACC_W - DAC_DATA_WID + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_ADC  = 3'd2;
  localparam logic [2:0] ST_CALC = 3'd3;
  localparam logic [2:0] ST_DAC  = 3'd4;

  localparam logic [ADC_WID_SIZ:0]  ADC_EDGES  = (ADC_WID_SIZ+1)'(2*ADC_WID);
  localparam logic [DAC_WID_SIZ:0]  DAC_EDGES  = (DAC_WID_SIZ+1)'(2*DAC_WID);
  localparam logic [DAC_WID_SIZ:0]  DAC_LAST   = (DAC_WID_SIZ+1)'(2*DAC_WID-1);
  localparam logic [CONSTS_SIZ-1:0] FRAC_SHIFT = CONSTS_SIZ'(CONSTS_FRAC);

  logic [2:0]                     state, resume_state;
  logic [DELAY_WID-1:0]           wait_cnt;
  logic [ADC_WID_SIZ:0]           adc_edge;
  logic [ADC_WID-1:0]             adc_shift;
  logic [DAC_WID_SIZ:0]           dac_edge;
  logic [DAC_WID-1:0]             dac_shift, dac_frame;
  logic                           run_en;
  logic signed [ADC_WID-1:0]      setpt, z_r;
  logic signed [CW-1:0]           p_gain, i_gain;
  logic [DELAY_WID-1:0]           delay;
  logic signed [ADC_WID:0]        err_r, err_c;
  logic signed [32:0]             sum_wide;
  logic signed [31:0]             sum_r, sum_c;
  logic [1:0]                     calc_step;
  logic signed [PP_W-1:0]         p_ext, e_ext, prod_p;
  logic signed [PI_W-1:0]         i_ext, s_ext, prod_i;
  logic signed [ACC_W-1:0]        acc_c, shifted_c;
  logic [TOP_W-1:0]               out_top;
  logic signed [DAC_DATA_WID-1:0] out_c, dac_data;
  logic [31:0]                    cycles;
  logic [CW-1:0]                  rd_word;
  logic                           unused_dac_miso;

  assign unused_dac_miso = dac_miso;
  assign in_loop         = (state != ST_IDLE);
  assign resume_state    = (delay == '0) ? ST_ADC : ST_WAIT;
  assign dac_frame       = DAC_WID'({4'b0001, dac_data});

  // Arithmetic for the PI step; everything is sign-extended to full width so
  // the multiplies and the final sum never wrap before the shift and clamp.
  always_comb begin
    err_c     = {setpt[ADC_WID-1], setpt} - {z_r[ADC_WID-1], z_r};
    sum_wide  = $signed({sum_r[31], sum_r}) + $signed({{(32-ADC_WID){err_c[ADC_WID]}}, err_c});
    sum_c     = sum_wide[31:0];
    if (sum_wide[32] != sum_wide[31])
      sum_c = sum_wide[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    p_ext     = $signed({{(PP_W-CW){p_gain[CW-1]}}, p_gain});
    e_ext     = $signed({{(PP_W-ADC_WID-1){err_r[ADC_WID]}}, err_r});
    i_ext     = $signed({{(PI_W-CW){i_gain[CW-1]}}, i_gain});
    s_ext     = $signed({{(PI_W-32){sum_r[31]}}, sum_r});
    acc_c     = $signed({{(ACC_W-PP_W){prod_p[PP_W-1]}}, prod_p})
              + $signed({{(ACC_W-PI_W){prod_i[PI_W-1]}}, prod_i});
    shifted_c = acc_c >>> FRAC_SHIFT;
    out_top   = shifted_c[ACC_W-1:DAC_DATA_WID-1];
    out_c     = shifted_c[DAC_DATA_WID-1:0];
    if (!((&out_top) || (~|out_top)))
      out_c = shifted_c[ACC_W-1] ? {1'b1, {(DAC_DATA_WID-1){1'b0}}}
                                 : {1'b0, {(DAC_DATA_WID-1){1'b1}}};
  end

  always_comb begin
    rd_word = '0;
    case (cmd[6:0])
      7'd2:    rd_word = {{(CW-1){1'b0}}, in_loop};
      7'd3:    rd_word = {{(CW-ADC_WID){setpt[ADC_WID-1]}}, setpt};
      7'd4:    rd_word = p_gain;
      7'd5:    rd_word = i_gain;
      7'd6:    rd_word = {{(CW-DELAY_WID){1'b0}}, delay};
      7'd7:    rd_word = {{(CW-ADC_WID-1){err_r[ADC_WID]}}, err_r};
      7'd8:    rd_word = {{(CW-ADC_WID){z_r[ADC_WID-1]}}, z_r};
      7'd9:    rd_word = {{(CW-32){1'b0}}, cycles};
      7'd10:   rd_word = {{(CW-DAC_DATA_WID){dac_data[DAC_DATA_WID-1]}}, dac_data};
      default: rd_word = '0;
    endcase
  end

  // finish_cmd doubles as the busy flag: no new command until it has fallen.
  always_ff @(posedge clk) begin
    if (rst_L) begin
      finish_cmd <= 1'b0;
      word_out   <= '0;
      run_en     <= 1'b0;
      setpt      <= '0;
      p_gain     <= '0;
      i_gain     <= '0;
      delay      <= '0;
    end else if (!finish_cmd) begin
      if (start_cmd) begin
        finish_cmd <= 1'b1;
        word_out   <= rd_word;
        if (cmd[7]) begin
          case (cmd[6:0])
            7'd1:    run_en <= word_in[0];
            7'd3:    setpt  <= word_in[ADC_WID-1:0];
            7'd4:    p_gain <= word_in;
            7'd5:    i_gain <= word_in;
            7'd6:    delay  <= word_in[DELAY_WID-1:0];
            default: ;
          endcase
        end
      end
    end else if (!start_cmd) begin
      finish_cmd <= 1'b0;
    end
  end

  // Loop sequencer; the SPI states spend their first cycle asserting select
  // so the first SCK edge always lands one clk after it.
  always_ff @(posedge clk) begin
    if (rst_L) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      adc_conv_L <= 1'b1;
      adc_sck    <= 1'(ADC_POLARITY);
      adc_edge   <= '0;
      adc_shift  <= '0;
      z_r        <= '0;
      err_r      <= '0;
      sum_r      <= '0;
      calc_step  <= '0;
      prod_p     <= '0;
      prod_i     <= '0;
      dac_data   <= '0;
      dac_ss_L   <= 1'b1;
      dac_sck    <= 1'(DAC_POLARITY);
      dac_mosi   <= 1'b0;
      dac_edge   <= '0;
      dac_shift  <= '0;
      cycles     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run_en) begin
            state    <= resume_state;
            wait_cnt <= DELAY_WID'(1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt >= delay) state <= ST_ADC;
          else                   wait_cnt <= wait_cnt + DELAY_WID'(1);
        end
        ST_ADC: begin
          if (adc_conv_L) begin
            adc_conv_L <= 1'b0;
            adc_edge   <= '0;
          end else if (adc_edge != ADC_EDGES) begin
            adc_sck  <= ~adc_sck;
            adc_edge <= adc_edge + (ADC_WID_SIZ+1)'(1);
            if (adc_edge[0] == 1'(ADC_PHASE))
              adc_shift <= {adc_shift[ADC_WID-2:0], adc_miso};
          end else begin
            adc_conv_L <= 1'b1;
            z_r        <= adc_shift;
            calc_step  <= '0;
            state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          case (calc_step)
            2'd0: begin
              err_r     <= err_c;
              sum_r     <= sum_c;
              calc_step <= 2'd1;
            end
            2'd1: begin
              prod_p    <= p_ext * e_ext;
              prod_i    <= i_ext * s_ext;
              calc_step <= 2'd2;
            end
            default: begin
              dac_data  <= out_c;
              calc_step <= 2'd0;
              state     <= ST_DAC;
            end
          endcase
        end
        ST_DAC: begin
          if (dac_ss_L) begin
            dac_ss_L <= 1'b0;
            dac_edge <= '0;
            if (DAC_PHASE == 0) begin
              dac_mosi  <= dac_frame[DAC_WID-1];
              dac_shift <= dac_frame << 1;
            end else begin
              dac_shift <= dac_frame;
            end
          end else if (dac_edge != DAC_EDGES) begin
            dac_sck  <= ~dac_sck;
            dac_edge <= dac_edge + (DAC_WID_SIZ+1)'(1);
            if ((dac_edge[0] != 1'(DAC_PHASE)) && (dac_edge != DAC_LAST)) begin
              dac_mosi  <= dac_shift[DAC_WID-1];
              dac_shift <= dac_shift << 1;
            end
          end else begin
            dac_ss_L <= 1'b1;
            dac_mosi <= 1'b0;
            cycles   <= cycles + 32'd1;
            wait_cnt <= DELAY_WID'(1);
            state    <= run_en ? resume_state : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_loop_pi.sv
// Bench for control_loop_pi: SPI ADC/DAC device models, host command driver
// and a plain-arithmetic PI reference model checked frame by frame.
module tb_control_loop_pi;

  logic        clk = 1'b0;
  logic        rst_L = 1'b1;
  logic        in_loop, adc_conv_L, adc_sck, adc_miso;
  logic        dac_ss_L, dac_sck, dac_mosi;
  logic        dac_miso = 1'b0;
  logic [63:0] word_in = '0;
  logic [63:0] word_out;
  logic        start_cmd = 1'b0;
  logic        finish_cmd;
  logic [7:0]  cmd = '0;

  int checks = 0;
  int errors = 0;

  logic [17:0] adc_value = '0;
  logic [4:0]  adc_bit = 5'd17;
  logic [23:0] dac_q[$];
  logic [23:0] got_q[$];

  longint            m_setpt, m_z, m_sum, m_err, m_dac;
  logic signed [63:0] m_p, m_i;
  int                m_cycles;

  always #5 clk = ~clk;

  control_loop_pi dut (
    .clk(clk), .rst_L(rst_L), .in_loop(in_loop),
    .adc_conv_L(adc_conv_L), .adc_sck(adc_sck), .adc_miso(adc_miso),
    .dac_ss_L(dac_ss_L), .dac_sck(dac_sck), .dac_mosi(dac_mosi), .dac_miso(dac_miso),
    .word_in(word_in), .word_out(word_out), .start_cmd(start_cmd),
    .finish_cmd(finish_cmd), .cmd(cmd)
  );

  // ADC device: MSB valid once convert falls, next bit after each rising SCK.
  assign adc_miso = adc_value[adc_bit];
  always begin
    @(negedge adc_conv_L);
    adc_bit = 5'd17;
    while (adc_bit > 0 && adc_conv_L == 1'b0) begin
      @(posedge adc_sck or posedge adc_conv_L);
      if (adc_conv_L == 1'b0) adc_bit = adc_bit - 5'd1;
    end
  end

  // DAC device: samples MOSI on falling SCK, keeps only complete frames.
  always begin
    logic [23:0] cap;
    int ncap;
    @(negedge dac_ss_L);
    cap = '0;
    ncap = 0;
    while (dac_ss_L == 1'b0) begin
      @(negedge dac_sck or posedge dac_ss_L);
      if (dac_ss_L == 1'b0) begin
        cap = {cap[22:0], dac_mosi};
        ncap++;
      end
    end
    if (ncap == 24) dac_q.push_back(cap);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic xfer(input logic [7:0] c, input logic [63:0] w, output logic [63:0] r);
    int lat;
    @(negedge clk);
    cmd = c;
    word_in = w;
    start_cmd = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (finish_cmd !== 1'b1 && lat < 8);
    checkOutput("cmd_latency", 64'(lat >= 1 && lat <= 2), 64'd1);
    r = word_out;
    start_cmd = 1'b0;
    @(negedge clk);
    checkOutput("cmd_release", 64'(finish_cmd), 64'd0);
  endtask

  task automatic wr(input int a, input logic [63:0] v);
    logic [63:0] r;
    xfer({1'b1, 7'(a)}, v, r);
  endtask

  task automatic rdChk(input string tag, input int a, input logic [63:0] expected);
    logic [63:0] r;
    xfer({1'b0, 7'(a)}, 64'd0, r);
    checkOutput(tag, r, expected);
  endtask

  task automatic doReset();
    start_cmd = 1'b0;
    rst_L = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_loop", 64'(in_loop), 64'd0);
    checkOutput("rst_finish", 64'(finish_cmd), 64'd0);
    checkOutput("rst_word_out", word_out, 64'd0);
    checkOutput("rst_adc_conv", 64'(adc_conv_L), 64'd1);
    checkOutput("rst_adc_sck", 64'(adc_sck), 64'd1);
    checkOutput("rst_dac_ss", 64'(dac_ss_L), 64'd1);
    checkOutput("rst_dac_sck", 64'(dac_sck), 64'd0);
    checkOutput("rst_dac_mosi", 64'(dac_mosi), 64'd0);
    rst_L = 1'b0;
    m_setpt = 0; m_z = 0; m_sum = 0; m_err = 0; m_dac = 0;
    m_p = '0; m_i = '0; m_cycles = 0;
    dac_q.delete();
  endtask

  task automatic setRegs(input longint sp, input logic signed [63:0] p, input logic signed [63:0] i,
                         input int dly, input longint adc);
    wr(3, 64'(sp));
    wr(4, p);
    wr(5, i);
    wr(6, 64'(dly));
    adc_value = 18'(adc);
    m_setpt = sp;
    m_p = p;
    m_i = i;
    m_z = adc;
  endtask

  // Reference PI step straight from the loop equations, in wide integers.
  task automatic predictFrame(output logic [23:0] f);
    longint err;
    logic signed [127:0] acc, pw, ew, iw, sw;
    logic [127:0] ou;
    err = m_setpt - m_z;
    m_sum = m_sum + err;
    if (m_sum > 64'sd2147483647) m_sum = 64'sd2147483647;
    else if (m_sum < -64'sd2147483648) m_sum = -64'sd2147483648;
    pw = m_p; ew = err; iw = m_i; sw = m_sum;
    acc = (pw * ew + iw * sw) >>> 43;
    if (acc > 128'sd524287) acc = 128'sd524287;
    else if (acc < -128'sd524288) acc = -128'sd524288;
    m_err = err;
    m_dac = longint'(acc);
    ou = acc;
    f = {4'b0001, ou[19:0]};
  endtask

  task automatic drainFrames();
    logic [23:0] f, e;
    got_q.delete();
    while (dac_q.size() > 0) begin
      f = dac_q.pop_front();
      predictFrame(e);
      checkOutput("dac_frame", 64'(f), 64'(e));
      got_q.push_back(f);
      m_cycles++;
    end
  endtask

  task automatic applyStimulus(input int n);
    wr(1, 64'd1);
    for (int k = 0; k < 400 * n && dac_q.size() < n; k++) @(negedge clk);
    checkOutput("frames_seen", 64'(dac_q.size() >= n), 64'd1);
    wr(1, 64'd0);
    for (int k = 0; k < 400 && in_loop; k++) @(negedge clk);
    checkOutput("loop_stopped", 64'(in_loop), 64'd0);
    drainFrames();
    rdChk("rd_cycles", 9, 64'(m_cycles));
    rdChk("rd_err", 7, 64'(m_err));
    rdChk("rd_z", 8, 64'(m_z));
    rdChk("rd_dac", 10, 64'(m_dac));
  endtask

  initial begin
    logic [17:0] r1, r2;
    logic signed [63:0] rp, ri;
    int base;

    $display("[TB] reset and register access");
    doReset();
    rdChk("status_idle", 2, 64'd0);
    wr(3, 64'd1000);
    rdChk("setpt_1000", 3, 64'd1000);
    wr(4, 64'hFFFF_FFFF_FFFF_FFFF);
    rdChk("p_minus1", 4, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(3, 64'h3FFFB);
    rdChk("setpt_sext", 3, 64'hFFFF_FFFF_FFFF_FFFB);
    wr(6, 64'hFFFF_FFFF);
    rdChk("delay_zext", 6, 64'h0000_0000_0000_FFFF);
    wr(7, 64'd123);
    rdChk("err_readonly", 7, 64'd0);
    rdChk("unknown_reg", 20, 64'd0);

    $display("[TB] P-only loop");
    setRegs(1000, 64'sh0000_0800_0000_0000, 64'sd0, 2, 0);
    applyStimulus(3);
    checkOutput("p_only_frame", 64'(got_q[0]), 64'h1003E8);

    $display("[TB] I accumulation");
    doReset();
    setRegs(100, 64'sd0, 64'sh0000_0400_0000_0000, 0, 0);
    applyStimulus(3);
    checkOutput("i_acc_0", 64'(got_q[0]), 64'h100032);
    checkOutput("i_acc_1", 64'(got_q[1]), 64'h100064);
    checkOutput("i_acc_2", 64'(got_q[2]), 64'h100096);

    $display("[TB] saturation");
    setRegs(1000, 64'sh4000_0000_0000_0000, 64'sd0, 0, 0);
    applyStimulus(1);
    checkOutput("sat_pos", 64'(got_q[0]), 64'h17FFFF);
    setRegs(-1000, 64'sh4000_0000_0000_0000, 64'sd0, 0, 1000);
    applyStimulus(1);
    checkOutput("sat_neg", 64'(got_q[0]), 64'h180000);

    $display("[TB] randomized runs");
    for (int t = 0; t < 5; t++) begin
      r1 = 18'($urandom);
      r2 = 18'($urandom);
      rp = $signed({$urandom, $urandom}) >>> 18;
      ri = $signed({$urandom, $urandom}) >>> 24;
      setRegs(longint'($signed(r1)), rp, ri, int'($urandom_range(0, 12)), longint'($signed(r2)));
      applyStimulus(2);
    end

    $display("[TB] stop during ADC");
    setRegs(-300, 64'sh0000_0800_0000_0000, 64'sh0000_0100_0000_0000, 0, 200);
    base = dac_q.size();
    wr(1, 64'd1);
    for (int k = 0; k < 100 && adc_conv_L; k++) @(negedge clk);
    checkOutput("adc_started", 64'(adc_conv_L), 64'd0);
    wr(1, 64'd0);
    for (int k = 0; k < 400 && in_loop; k++) @(negedge clk);
    checkOutput("stop_in_loop", 64'(in_loop), 64'd0);
    checkOutput("stop_one_frame", 64'(dac_q.size() - base), 64'd1);
    drainFrames();
    rdChk("stop_cycles", 9, 64'(m_cycles));

    $display("[TB] reset during DAC frame");
    wr(1, 64'd1);
    for (int k = 0; k < 400 && dac_ss_L; k++) @(negedge clk);
    checkOutput("dac_started", 64'(dac_ss_L), 64'd0);
    repeat (4) @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_dac_ss", 64'(dac_ss_L), 64'd1);
    checkOutput("abort_in_loop", 64'(in_loop), 64'd0);
    checkOutput("abort_dac_sck", 64'(dac_sck), 64'd0);
    doReset();
    rdChk("post_rst_status", 2, 64'd0);
    rdChk("post_rst_cycles", 9, 64'd0);
    checkOutput("post_rst_noframe", 64'(dac_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
